// File: rtl/frequency_display_pkg.sv
// freq_disp_pkg
//   Shared definitions for the frequency display block:
//   - disp_state_t : conversion FSM states (IDLE, SHIFT, DONE)
//   - SEG_LUT      : active-low 7-segment patterns {dp,g,f,e,d,c,b,a} for 0..9
//   - SEG_BLANK    : all segments off
//   - disp_max()   : largest displayable value, 10^digits - 1
//   - disp_bin_w() : bits needed to hold disp_max(), i.e. $clog2(10^digits)
//   - seg_decode() : nibble to segment pattern; non-decimal nibbles blank
package freq_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } disp_state_t;

   localparam logic [7:0] SEG_LUT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [63:0] disp_max(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   function automatic int disp_bin_w(input int digits);
      logic [63:0] m;
      int          w;
      m = disp_max(digits);
      w = 0;
      for (int i = 0; i < 64; i++) begin
         if (m[i]) w = i + 1;
      end
      return w;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      s = SEG_BLANK;
      if (d <= 4'd9) s = SEG_LUT[d];
      return s;
   endfunction

endpackage

// File: rtl/frequency_display_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter with a single-entry pending slot.
//   Ports:
//     clk_fs    in   clock
//     rst       in   synchronous active-high reset
//     start     in   one-cycle strobe, bin is valid while start is high
//     bin       in   BIN_W-bit binary value (already saturated by the caller)
//     bcd       out  packed BCD result, digit 0 in [3:0], held until next DONE
//     done      out  one-cycle pulse coincident with a bcd update
//     busy      out  high whenever the FSM is not IDLE
//     dbg_state out  current FSM state
//
//   Handshake: start is a pure valid strobe with no back-pressure. A strobe
//   that arrives while busy is parked in the pending slot (latest wins) and is
//   converted as soon as the current conversion reaches DONE; a strobe that
//   lands exactly on DONE is converted directly from DONE.
module bin2bcd_seq
   import freq_disp_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
) (
   input  logic                clk_fs,
   input  logic                rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic                done,
   output logic                busy,
   output disp_state_t         dbg_state
);

   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   disp_state_t         state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [4*DIGITS-1:0] acc_q, acc_d;
   logic [4*DIGITS-1:0] acc_adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pend_q, pend_d;
   logic [BIN_W-1:0]    pend_val_q, pend_val_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                done_q, done_d;

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      bcd_d      = bcd_q;
      done_d     = 1'b0;

      // Add-3 correction on every nibble that would overflow past 9 after
      // the following doubling.
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end

      if (start && (state_q != IDLE)) begin
         pend_val_d = bin;
         pend_d     = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, bin_d} = {acc_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CW'(BIN_W - 1)) state_d = DONE;
         end
         DONE: begin
            bcd_d  = acc_q;
            done_d = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
            if (start) begin
               bin_d   = bin;
               state_d = SHIFT;
            end else if (pend_q) begin
               bin_d   = pend_val_q;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_fs) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         bcd_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         bcd_q      <= bcd_d;
         done_q     <= done_d;
      end
   end

   assign bcd       = bcd_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: rtl/frequency_display.sv
// frequency_display
//   Captures each fre word, saturates it to 10^DIGITS-1, converts it to BCD
//   and scans it onto a multiplexed active-low 7-segment display with
//   leading-zero blanking. Everything runs on clk_fs.
//   Ports:
//     clk_fs   in   clock (same as the frequency counter)
//     rst      in   synchronous active-high reset
//     fre      in   measured frequency, valid while fre_vld is high
//     fre_vld  in   one-cycle strobe marking a new fre
//     bcd      out  packed BCD, digit 0 in [3:0]
//     bcd_vld  out  one-cycle pulse when bcd updates
//     ovf      out  last converted fre exceeded 10^DIGITS-1
//     busy     out  a conversion is in progress
//     seg      out  active-low {dp,g,f,e,d,c,b,a}
//     dig_sel  out  active-low one-hot digit enable
module frequency_display
   import freq_disp_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000,
   parameter int FRE_W    = 64
) (
   input  logic                clk_fs,
   input  logic                rst,
   input  logic [FRE_W-1:0]    fre,
   input  logic                fre_vld,
   output logic [4*DIGITS-1:0] bcd,
   output logic                bcd_vld,
   output logic                ovf,
   output logic                busy,
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   dig_sel
);

   localparam int               BIN_W   = disp_bin_w(DIGITS);
   localparam logic [FRE_W-1:0] MAX_FRE = FRE_W'(disp_max(DIGITS));
   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(disp_max(DIGITS));
   localparam int               PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int               IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                ovf_new;
   logic [BIN_W-1:0]    sat;
   logic [4*DIGITS-1:0] bcd_w;
   logic                done_w;
   logic                busy_w;
   disp_state_t         conv_state;

   assign ovf_new = (fre > MAX_FRE);
   assign sat     = ovf_new ? MAX_BIN : fre[BIN_W-1:0];

   bin2bcd_seq #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_bin2bcd (
      .clk_fs    (clk_fs),
      .rst       (rst),
      .start     (fre_vld),
      .bin       (sat),
      .bcd       (bcd_w),
      .done      (done_w),
      .busy      (busy_w),
      .dbg_state (conv_state)
   );

   // The overflow flag travels alongside the value through the converter:
   // ovf_act belongs to the conversion in flight, ovf_pend to the parked one.
   logic ovf_q, ovf_d;
   logic ovf_act_q, ovf_act_d;
   logic ovf_pend_q, ovf_pend_d;

   always_comb begin
      ovf_d      = ovf_q;
      ovf_act_d  = ovf_act_q;
      ovf_pend_d = ovf_pend_q;
      if (fre_vld) begin
         if (!busy_w) ovf_act_d  = ovf_new;
         else         ovf_pend_d = ovf_new;
      end
      if (conv_state == DONE) begin
         ovf_d     = ovf_act_q;
         // The next conversion out of DONE takes a same-cycle strobe first,
         // otherwise the parked value.
         ovf_act_d = fre_vld ? ovf_new : ovf_pend_q;
      end
   end

   // Display scan
   logic [PW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              tick;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
   logic [DIGITS-1:0] blank;
   logic              lz;
   logic [3:0]        nib;

   always_comb begin
      presc_d = presc_q + 1'b1;
      tick    = 1'b0;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         tick    = 1'b1;
      end

      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

      // Walk from the most significant digit down: a digit is blank while
      // it and everything above it is zero. Digit 0 always shows.
      lz    = 1'b1;
      blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lz       = lz & (bcd_w[4*i +: 4] == 4'd0);
         blank[i] = lz && (i > 0);
      end

      // Outputs are computed for the index being entered so that seg and
      // dig_sel switch on the same edge.
      nib   = bcd_w[{idx_d, 2'b00} +: 4];
      seg_d = seg_decode(nib);
      if (blank[idx_d]) seg_d[6:0] = 7'h7F;
      seg_d[7]  = ~((idx_d == '0) && ovf_q);
      dig_sel_d = ~(DIGITS'(1) << idx_d);
   end

   always_ff @(posedge clk_fs) begin
      if (rst) begin
         ovf_q      <= 1'b0;
         ovf_act_q  <= 1'b0;
         ovf_pend_q <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= SEG_BLANK;
         dig_sel_q  <= '1;
      end else begin
         ovf_q      <= ovf_d;
         ovf_act_q  <= ovf_act_d;
         ovf_pend_q <= ovf_pend_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dig_sel_q  <= dig_sel_d;
      end
   end

   assign bcd     = bcd_w;
   assign bcd_vld = done_w;
   assign ovf     = ovf_q;
   assign busy    = busy_w;
   assign seg     = seg_q;
   assign dig_sel = dig_sel_q;

endmodule
